// File: rtl/orbtrace_uart_pkg.sv
// Shared definitions for the UART transmit path: byte type, default FIFO depth
// and the feeder sequencer state encoding.
package orbtrace_uart_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int BYTE_W        = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_feeder_byte_fifo.sv
// Circular byte FIFO with an explicit fill counter, so full/empty never depend
// on pointer equality. Flush clears pointers and count and wins over push/pop.
module byte_fifo
    import orbtrace_uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  byte_t       push_data,
    input  logic        pop,
    output byte_t       pop_data,
    input  logic        flush,
    output logic [AW:0] fill,
    output logic        full,
    output logic        empty
);

    byte_t         mem [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;

    assign full     = (fill == (AW+1)'(DEPTH));
    assign empty    = (fill == '0);
    assign pop_data = mem[rd];

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd   <= '0;
            wr   <= '0;
            fill <= '0;
        end else if (flush) begin
            rd   <= '0;
            wr   <= '0;
            fill <= '0;
        end else begin
            if (push)
                wr <= wr + AW'(1);
            if (pop)
                rd <= rd + AW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers upstream bytes and hands them to the UART one at a time using its
// single-cycle transmit strobe and tx_free level; reports fill and overflow.
module uart_tx_feeder
    import orbtrace_uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        tx_free,
    output logic [AW:0] fill,
    output logic        overflow
);

    tx_state_t state;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    byte_t     pop_data;

    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;
    // No new strobe on a flush edge: the byte at the head is being discarded.
    assign pop      = (state == ST_IDLE) && !empty && tx_free && !flush;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .flush     (flush),
        .fill      (fill),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (in_valid && full) begin
            overflow <= 1'b1;
        end
    end

    // tx_free is still stale-high in ISSUE, so it is only looked at in IDLE/WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            transmit <= 1'b0;
            tx_byte  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        transmit <= 1'b1;
                        tx_byte  <= pop_data;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    transmit <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_free)
                        state <= ST_IDLE;
                end
                default: begin
                    transmit <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a cycle table for the basic handshake,
// then hand sequences for full/overflow, wrap with a UART model, flush and reset.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       tx_free;
    logic [4:0] fill;
    logic       overflow;

    logic man_free;
    logic bfm_en;
    logic bfm_free = 1'b1;
    int   bfm_cnt  = 0;
    logic prev_tx  = 1'b0;
    int   dbl_cnt  = 0;
    int   busy_cnt = 0;
    logic [7:0] rx_q [$];

    int checks = 0;
    int passes = 0;

    assign tx_free = bfm_en ? bfm_free : man_free;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .transmit (transmit),
        .tx_byte  (tx_byte),
        .tx_free  (tx_free),
        .fill     (fill),
        .overflow (overflow)
    );

    // Strobe capture plus a UART model that stays busy 40 cycles per frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (transmit) begin
                rx_q.push_back(tx_byte);
                if (prev_tx) dbl_cnt++;
                if (bfm_en && !bfm_free) busy_cnt++;
            end
            prev_tx = transmit;
            if (bfm_en) begin
                if (transmit) begin
                    bfm_free = 1'b0;
                    bfm_cnt  = 40;
                end else if (bfm_cnt > 0) begin
                    bfm_cnt--;
                    if (bfm_cnt == 0) bfm_free = 1'b1;
                end
            end
        end else begin
            prev_tx = 1'b0;
        end
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       fr;
        logic       e_rdy;
        logic       e_tx;
        logic [7:0] e_byte;
        logic [4:0] e_fill;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cyc(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Offers a byte only once in_ready is high, so waiting never flags overflow.
    task automatic push_wait(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_wait timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (rx_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("strobe wait timeout", rx_q.size(), target);
    endtask

    initial begin
        int base;
        int n;

        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0};
        tbl[5]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd1};
        tbl[6]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd2};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 5'd1};
        tbl[8]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h3C, 5'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 5'd2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h7E, 5'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h7E, 5'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h7E, 5'd1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 5'd0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, 5'd0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 5'd0};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
        man_free = 1'b1; bfm_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset transmit", transmit, 0);
        chk("reset tx_byte",  tx_byte,  0);
        chk("reset fill",     fill,     0);
        chk("reset overflow", overflow, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Cycle table: single 0xA5, then two queued bytes and one pushed mid-frame.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            man_free = tbl[i].fr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d transmit", i), transmit, tbl[i].e_tx);
            chk($sformatf("vec%0d tx_byte",  i), tx_byte,  tbl[i].e_byte);
            chk($sformatf("vec%0d fill",     i), fill,     tbl[i].e_fill);
            chk($sformatf("vec%0d overflow", i), overflow, 0);
        end
        in_valid = 1'b0;

        // Fill to DEPTH with the UART busy, overflow on the 17th byte.
        @(negedge clk);
        man_free = 1'b0;
        tick();
        base = rx_q.size();
        for (int k = 1; k <= 16; k++) push_cyc(8'(k));
        chk("full fill",     fill,     16);
        chk("full in_ready", in_ready, 0);
        chk("full overflow", overflow, 0);
        push_cyc(8'h11);
        chk("ovf flag",      overflow, 1);
        chk("ovf fill",      fill,     16);
        @(negedge clk);
        bfm_en = 1'b1;
        wait_strobes(base + 16, 1200);
        repeat (60) tick();
        chk("full drain count", rx_q.size() - base, 16);
        for (int k = 1; k <= 16; k++)
            if (rx_q.size() >= base + k) chk($sformatf("full order %0d", k), rx_q[base+k-1], k);
        chk("full drain fill", fill, 0);

        // 20 bytes through the wrap point, paced by the UART model.
        base = rx_q.size();
        for (int k = 0; k < 20; k++) push_wait(8'h60 + 8'(k));
        wait_strobes(base + 20, 1500);
        for (int k = 0; k < 20; k++)
            if (rx_q.size() >= base + k + 1) chk($sformatf("wrap order %0d", k), rx_q[base+k], 8'h60 + 8'(k));
        chk("overflow sticky", overflow, 1);
        n = 0;
        while (!bfm_free && n < 100) begin tick(); n++; end
        chk("bfm idle", bfm_free, 1);
        chk("double strobes", dbl_cnt, 0);
        chk("strobe while busy", busy_cnt, 0);
        @(negedge clk);
        man_free = 1'b1;
        bfm_en   = 1'b0;
        repeat (4) tick();

        // Push and pop on the same edge with fill=5.
        @(negedge clk);
        man_free = 1'b0;
        base = rx_q.size();
        for (int k = 0; k < 5; k++) push_cyc(8'h21 + 8'(k));
        chk("pp fill before", fill, 5);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h26; man_free = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pp fill same",   fill,     5);
        chk("pp transmit",    transmit, 1);
        chk("pp tx_byte",     tx_byte,  8'h21);
        repeat (30) tick();
        chk("pp count", rx_q.size() - base, 6);
        for (int k = 0; k < 6; k++)
            if (rx_q.size() >= base + k + 1) chk($sformatf("pp order %0d", k), rx_q[base+k], 8'h21 + 8'(k));
        chk("pp fill end", fill, 0);

        // Flush with fill=7, overflow set, strobe in flight, and a push of 0x55.
        @(negedge clk);
        man_free = 1'b0;
        base = rx_q.size();
        for (int k = 0; k < 16; k++) push_cyc(8'h41 + 8'(k));
        push_cyc(8'h5A);
        chk("fl overflow set", overflow, 1);
        @(negedge clk);
        man_free = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(fill == 7 && transmit) && n < 100);
        chk("fl reached fill7 strobe", (fill == 7 && transmit) ? 1 : 0, 1);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl fill",     fill,     0);
        chk("fl overflow", overflow, 0);
        chk("fl transmit", transmit, 0);
        chk("fl in_ready", in_ready, 1);
        repeat (30) tick();
        chk("fl strobe count", rx_q.size() - base, 9);
        if (rx_q.size() > 0) chk("fl last byte", rx_q[rx_q.size()-1], 8'h49);
        chk("fl fill after", fill, 0);
        chk("fl overflow after", overflow, 0);

        // Async reset in the middle of ISSUE.
        @(negedge clk);
        man_free = 1'b0;
        push_cyc(8'h81);
        push_cyc(8'h82);
        @(negedge clk);
        man_free = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!transmit && n < 20);
        chk("rst saw strobe", transmit, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst transmit", transmit, 0);
        chk("rst fill",     fill,     0);
        chk("rst tx_byte",  tx_byte,  0);
        chk("rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        base = rx_q.size();
        push_cyc(8'h9A);
        chk("post-rst fill", fill, 1);
        tick();
        chk("post-rst transmit", transmit, 1);
        chk("post-rst tx_byte",  tx_byte,  8'h9A);
        tick();
        chk("post-rst transmit low", transmit, 0);
        repeat (5) tick();
        chk("post-rst count", rx_q.size() - base, 1);
        chk("final double strobes", dbl_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
